// File: rtl/nmr_pkg.sv
// nmr_pkg: shared helpers for the N-modular-redundant voting register.
//   rep_cnt_w : width needed to hold a replica count 0..n, i.e. clog2(n+1)
//   popcount  : number of set bits in a vector of up to MAX_N replicas
//   sat_inc   : increment that sticks at 2^w-1 instead of wrapping
package nmr_pkg;

   localparam int unsigned MAX_N = 64;

   function automatic int unsigned rep_cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic logic [7:0] popcount(input logic [MAX_N-1:0] v);
      logic [7:0] c;
      c = '0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         c = c + 8'(v[i]);
      end
      return c;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      if (v == ((32'd1 << w) - 32'd1)) begin
         return v;
      end
      return v + 32'd1;
   endfunction

endpackage

// File: rtl/nmr_bit_vote.sv
// nmr_bit_vote: majority vote of one bit position across N replicas.
//   data     : bit value from each replica
//   en       : 1 = that replica's bit is still trusted
//   vote     : majority value among enabled replicas (0 on a tie)
//   tie      : no strict majority (includes no replica enabled)
//   disagree : enabled replica that differs from a real majority
module nmr_bit_vote
   import nmr_pkg::*;
#(
   parameter int unsigned N = 7
) (
   input  logic [N-1:0] data,
   input  logic [N-1:0] en,
   output logic         vote,
   output logic         tie,
   output logic [N-1:0] disagree
);

   // One extra bit so that 2*ones never overflows.
   localparam int unsigned EW = rep_cnt_w(N) + 1;

   logic [EW-1:0] ones;
   logic [EW-1:0] enabled;

   always_comb begin
      ones     = EW'(popcount(MAX_N'(data & en)));
      enabled  = EW'(popcount(MAX_N'(en)));
      vote     = (ones << 1) > enabled;
      tie      = (ones << 1) == enabled;
      disagree = '0;
      if (!tie) begin
         disagree = en & (data ^ {N{vote}});
      end
   end

endmodule

// File: rtl/nmr_vote_reg.sv
// nmr_vote_reg: N-modular-redundant pipeline register with bit-wise voting,
// sticky per-bit trust masks, per-replica saturating fault counters and a
// valid/ready handshake (1-cycle latency, full throughput).
//   clk, reset_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready     : replica vector handshake; in_data holds replica i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready   : voted word handshake; out_data is the voted word
//   out_nomaj             : at least one bit of out_data had no majority
//   mask                  : 1 = replica bit still trusted, same layout as in_data
//   rep_dead              : replica i has no trusted bits left
//   fault_cnt             : replica i disagreement count at [i*CNT_W +: CNT_W]
//   scrub_req             : only with NMR_SCRUB_EN defined; restores all masks to 1
module nmr_vote_reg
   import nmr_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 7,
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
`ifdef NMR_SCRUB_EN
   input  logic                 scrub_req,
`endif
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_nomaj,
   output logic [N*WIDTH-1:0]   mask,
   output logic [N-1:0]         rep_dead,
   output logic [N*CNT_W-1:0]   fault_cnt
);

   logic                 scrub;
   logic                 accept;
   logic [WIDTH-1:0]     vote;
   logic [WIDTH-1:0]     tie;
   logic [N*WIDTH-1:0]   clr;
   logic [N-1:0]         hit;
   logic [N*WIDTH-1:0]   mask_q;
   logic [CNT_W-1:0]     cnt_q [N];
   logic                 out_valid_q;
   logic [WIDTH-1:0]     out_data_q;
   logic                 out_nomaj_q;

`ifdef NMR_SCRUB_EN
   assign scrub = scrub_req;
`else
   assign scrub = 1'b0;
`endif

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Transpose replica-major buses into per-bit voter slices.
   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [N-1:0] d;
      logic [N-1:0] e;
      logic [N-1:0] dis;
      for (genvar i = 0; i < N; i++) begin : g_rep
         assign d[i]              = in_data[i*WIDTH+b];
         assign e[i]              = mask_q[i*WIDTH+b];
         assign clr[i*WIDTH+b]    = dis[i];
      end
      nmr_bit_vote #(.N(N)) u_vote (
         .data     (d),
         .en       (e),
         .vote     (vote[b]),
         .tie      (tie[b]),
         .disagree (dis)
      );
   end

   always_comb begin
      hit       = '0;
      rep_dead  = '0;
      fault_cnt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         hit[i]                      = |clr[i*WIDTH +: WIDTH];
         rep_dead[i]                 = ~|mask_q[i*WIDTH +: WIDTH];
         fault_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_nomaj_q <= 1'b0;
         mask_q      <= '1;
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= vote;
            out_nomaj_q <= |tie;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end

         // A concurrent accept still votes with the old masks; scrub overrides its mask update.
         if (scrub) begin
            mask_q <= '1;
         end else if (accept) begin
            mask_q <= mask_q & ~clr;
         end

         for (int unsigned i = 0; i < N; i++) begin
            if (accept && hit[i]) begin
               cnt_q[i] <= CNT_W'(sat_inc(32'(cnt_q[i]), CNT_W));
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_nomaj = out_nomaj_q;
   assign mask      = mask_q;

endmodule

// File: tb/tb_nmr_vote_reg.sv
// tb_nmr_vote_reg: directed self-checking bench for nmr_vote_reg with
// N=3, WIDTH=8, CNT_W=2. Define NMR_SCRUB_EN to also exercise scrub_req.
module tb_nmr_vote_reg;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_nomaj;
   logic [23:0] mask;
   logic [2:0]  rep_dead;
   logic [5:0]  fault_cnt;
`ifdef NMR_SCRUB_EN
   logic        scrub_req = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nmr_vote_reg #(.WIDTH(8), .N(3), .CNT_W(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
`ifdef NMR_SCRUB_EN
      .scrub_req (scrub_req),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_nomaj (out_nomaj),
      .mask      (mask),
      .rep_dead  (rep_dead),
      .fault_cnt (fault_cnt)
   );

   // One accepted transfer; outputs are sampled 1 time unit after the edge.
   task automatic xfer(input logic [23:0] d);
      @(negedge clk);
      in_data   = d;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", out_data); end
      n_tests++; if (out_nomaj !== 1'b0) begin n_fail++; $display("FAIL reset_nomaj got=%b exp=0", out_nomaj); end
      n_tests++; if (mask !== 24'hFFFFFF) begin n_fail++; $display("FAIL reset_mask got=%h exp=ffffff", mask); end
      n_tests++; if (fault_cnt !== 6'h00) begin n_fail++; $display("FAIL reset_cnt got=%h exp=00", fault_cnt); end
      n_tests++; if (rep_dead !== 3'b000) begin n_fail++; $display("FAIL reset_dead got=%b exp=000", rep_dead); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      xfer({8'hA5, 8'hA5, 8'hA5});
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got=%h exp=a5", out_data); end
      n_tests++; if (out_nomaj !== 1'b0) begin n_fail++; $display("FAIL basic_nomaj got=%b exp=0", out_nomaj); end
      n_tests++; if (mask !== 24'hFFFFFF) begin n_fail++; $display("FAIL basic_mask got=%h exp=ffffff", mask); end
      n_tests++; if (fault_cnt !== 6'h00) begin n_fail++; $display("FAIL basic_cnt got=%h exp=00", fault_cnt); end
   endtask

   task automatic test_fault();
      xfer({8'hA5, 8'hA4, 8'hA5});
      n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL fault1_data got=%h exp=a5", out_data); end
      n_tests++; if (mask !== 24'hFFFEFF) begin n_fail++; $display("FAIL fault1_mask got=%h exp=fffeff", mask); end
      n_tests++; if (fault_cnt !== 6'h04) begin n_fail++; $display("FAIL fault1_cnt got=%h exp=04", fault_cnt); end
      xfer({8'hA4, 8'hA5, 8'hA4});
      n_tests++; if (out_data !== 8'hA4) begin n_fail++; $display("FAIL fault2_data got=%h exp=a4", out_data); end
      n_tests++; if (out_nomaj !== 1'b0) begin n_fail++; $display("FAIL fault2_nomaj got=%b exp=0", out_nomaj); end
      n_tests++; if (mask !== 24'hFFFEFF) begin n_fail++; $display("FAIL fault2_mask got=%h exp=fffeff", mask); end
      n_tests++; if (fault_cnt !== 6'h04) begin n_fail++; $display("FAIL fault2_cnt got=%h exp=04", fault_cnt); end
   endtask

   task automatic test_tie();
      // Replica 1 bit0 is masked, so bit0 is voted by replicas 0 (=0) and 2 (=1).
      xfer({8'hA5, 8'hA5, 8'hA4});
      n_tests++; if (out_data !== 8'hA4) begin n_fail++; $display("FAIL tie_data got=%h exp=a4", out_data); end
      n_tests++; if (out_nomaj !== 1'b1) begin n_fail++; $display("FAIL tie_nomaj got=%b exp=1", out_nomaj); end
      n_tests++; if (mask !== 24'hFFFEFF) begin n_fail++; $display("FAIL tie_mask got=%h exp=fffeff", mask); end
      n_tests++; if (fault_cnt !== 6'h04) begin n_fail++; $display("FAIL tie_cnt got=%h exp=04", fault_cnt); end
   endtask

   task automatic test_stall();
      xfer({8'hA5, 8'hA5, 8'hA5});
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {8'h00, 8'hFF, 8'h00};
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", c, out_valid); end
         n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL stall_data cyc=%0d got=%h exp=a5", c, out_data); end
         n_tests++; if (mask !== 24'hFFFEFF) begin n_fail++; $display("FAIL stall_mask cyc=%0d got=%h exp=fffeff", c, mask); end
         n_tests++; if (fault_cnt !== 6'h04) begin n_fail++; $display("FAIL stall_cnt cyc=%0d got=%h exp=04", c, fault_cnt); end
         n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, in_ready); end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_saturate();
      logic [7:0] exp_m2;
      logic [1:0] exp_c2;
      logic [2:0] exp_dead;
      do_reset();
      exp_m2 = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         xfer({8'(1 << k), 8'h00, 8'h00});
         exp_m2   = exp_m2 & ~8'(1 << k);
         exp_c2   = (k >= 2) ? 2'd3 : 2'(k + 1);
         exp_dead = (k == 7) ? 3'b100 : 3'b000;
         n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL sat_data k=%0d got=%h exp=00", k, out_data); end
         n_tests++; if (mask !== {exp_m2, 16'hFFFF}) begin n_fail++; $display("FAIL sat_mask k=%0d got=%h exp=%h", k, mask, {exp_m2, 16'hFFFF}); end
         n_tests++; if (fault_cnt !== {exp_c2, 4'h0}) begin n_fail++; $display("FAIL sat_cnt k=%0d got=%h exp=%h", k, fault_cnt, {exp_c2, 4'h0}); end
         n_tests++; if (rep_dead !== exp_dead) begin n_fail++; $display("FAIL sat_dead k=%0d got=%b exp=%b", k, rep_dead, exp_dead); end
      end
      // Replica 2 dead: only replicas 0 and 1 vote.
      xfer({8'hC3, 8'h3C, 8'h3C});
      n_tests++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL dead_data got=%h exp=3c", out_data); end
      n_tests++; if (out_nomaj !== 1'b0) begin n_fail++; $display("FAIL dead_nomaj got=%b exp=0", out_nomaj); end
      n_tests++; if (mask !== 24'h00FFFF) begin n_fail++; $display("FAIL dead_mask got=%h exp=00ffff", mask); end
      xfer({8'hFF, 8'hF0, 8'h0F});
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL deadtie_data got=%h exp=00", out_data); end
      n_tests++; if (out_nomaj !== 1'b1) begin n_fail++; $display("FAIL deadtie_nomaj got=%b exp=1", out_nomaj); end
      n_tests++; if (mask !== 24'h00FFFF) begin n_fail++; $display("FAIL deadtie_mask got=%h exp=00ffff", mask); end
      n_tests++; if (fault_cnt !== 6'h30) begin n_fail++; $display("FAIL deadtie_cnt got=%h exp=30", fault_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3];
      vals[0] = 8'h11;
      vals[1] = 8'h22;
      vals[2] = 8'h33;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = {8'hFF, vals[j], vals[j]};
         #1;
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready j=%0d got=%b exp=1", j, in_ready); end
         @(posedge clk);
         #1;
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid j=%0d got=%b exp=1", j, out_valid); end
         n_tests++; if (out_data !== vals[j]) begin n_fail++; $display("FAIL b2b_data j=%0d got=%h exp=%h", j, out_data, vals[j]); end
      end
   endtask

   task automatic test_reset_mid_stall();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_hold got=%b exp=1", out_valid); end
      #2 reset_n = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data got=%h exp=00", out_data); end
      n_tests++; if (mask !== 24'hFFFFFF) begin n_fail++; $display("FAIL midrst_mask got=%h exp=ffffff", mask); end
      n_tests++; if (fault_cnt !== 6'h00) begin n_fail++; $display("FAIL midrst_cnt got=%h exp=00", fault_cnt); end
      n_tests++; if (rep_dead !== 3'b000) begin n_fail++; $display("FAIL midrst_dead got=%b exp=000", rep_dead); end
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b1;
   endtask

`ifdef NMR_SCRUB_EN
   task automatic test_scrub();
      @(negedge clk);
      scrub_req = 1'b1;
      xfer({8'hA5, 8'hA4, 8'hA5});
      scrub_req = 1'b0;
      n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL scrub_data got=%h exp=a5", out_data); end
      n_tests++; if (mask !== 24'hFFFFFF) begin n_fail++; $display("FAIL scrub_mask got=%h exp=ffffff", mask); end
      n_tests++; if (fault_cnt !== 6'h04) begin n_fail++; $display("FAIL scrub_cnt got=%h exp=04", fault_cnt); end
      xfer({8'hA5, 8'hA4, 8'hA5});
      n_tests++; if (mask !== 24'hFFFEFF) begin n_fail++; $display("FAIL scrub_refault got=%h exp=fffeff", mask); end
      @(negedge clk);
      scrub_req = 1'b1;
      @(posedge clk);
      #1;
      scrub_req = 1'b0;
      n_tests++; if (mask !== 24'hFFFFFF) begin n_fail++; $display("FAIL scrub_idle_mask got=%h exp=ffffff", mask); end
      n_tests++; if (fault_cnt !== 6'h08) begin n_fail++; $display("FAIL scrub_idle_cnt got=%h exp=08", fault_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_fault();
      test_tie();
      test_stall();
      test_saturate();
      test_back_to_back();
      test_reset_mid_stall();
`ifdef NMR_SCRUB_EN
      test_scrub();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
